// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes and the master arbiter FSM state.
package axi4_lite_pkg;

  localparam int AXI4_LITE_MAX_REQ = 8;

  typedef enum logic [1:0] {
    AXI4_RESP_OKAY   = 2'b00,
    AXI4_RESP_EXOKAY = 2'b01,
    AXI4_RESP_SLVERR = 2'b10,
    AXI4_RESP_DECERR = 2'b11
  } axi4_resp_t;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_WR,
    ARB_WR_RESP,
    ARB_RD,
    ARB_RD_DATA,
    ARB_RSP
  } arb_state_t;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_if #(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32
);
  logic [ADDR_BIT_WIDTH-1:0]   awaddr;
  logic [2:0]                  awprot;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_BIT_WIDTH-1:0]   wdata;
  logic [DATA_BIT_WIDTH/8-1:0] wstrb;
  logic                        wvalid;
  logic                        wready;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;
  logic [ADDR_BIT_WIDTH-1:0]   araddr;
  logic [2:0]                  arprot;
  logic                        arvalid;
  logic                        arready;
  logic [DATA_BIT_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rvalid;
  logic                        rready;

  modport mst_port (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slv_port (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] src;

  // Requests at/above the pointer win; otherwise wrap to the lowest index.
  always_comb begin
    masked = '0;
    for (int k = 0; k < N_REQ; k++) masked[k] = req[k] && (k >= int'(ptr));
    src     = (|masked) ? masked : req;
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (src[k]) begin
        gnt_oh    = '0;
        gnt_oh[k] = 1'b1;
        gnt_idx   = IDX_W'(k);
      end
    end
  end

  assign gnt_any = |req;
endmodule

// File: rtl/axi4_lite_mst_arbiter.sv
// N-requester AXI4-Lite master: one single-beat transaction at a time.
// AXI4_LITE_MST_ARB_FIXED_PRIO_EN selects fixed priority (lowest index) instead of round-robin.
module axi4_lite_mst_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32
) (
  input  logic                              i_clk,
  input  logic                              i_sync_rst_n,
  input  logic [N_REQ-1:0]                  i_req_valid,
  output logic [N_REQ-1:0]                  o_req_ready,
  input  logic [N_REQ-1:0]                  i_req_is_wr,
  input  logic [N_REQ*ADDR_BIT_WIDTH-1:0]   i_req_addr,
  input  logic [N_REQ*DATA_BIT_WIDTH-1:0]   i_req_wdata,
  input  logic [N_REQ*DATA_BIT_WIDTH/8-1:0] i_req_wstrb,
  output logic [N_REQ-1:0]                  o_rsp_valid,
  output logic [DATA_BIT_WIDTH-1:0]         o_rsp_rdata,
  output logic [1:0]                        o_rsp_resp,
  output logic                              o_busy,
  axi4_lite_if.mst_port                     if_m_axi4_lite
);
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STRB_W = DATA_BIT_WIDTH / 8;

  if (if_m_axi4_lite.ADDR_BIT_WIDTH != ADDR_BIT_WIDTH) begin : g_addr_w_chk
    $error("ADDR_BIT_WIDTH does not match the AXI4-Lite interface");
  end
  if (if_m_axi4_lite.DATA_BIT_WIDTH != DATA_BIT_WIDTH) begin : g_data_w_chk
    $error("DATA_BIT_WIDTH does not match the AXI4-Lite interface");
  end
  if (N_REQ < 2 || N_REQ > AXI4_LITE_MAX_REQ) begin : g_nreq_chk
    $error("N_REQ must be in 2..8");
  end

  arb_state_t                state_q, state_d;
  logic [IDX_W-1:0]          gnt_q, gnt_d;
  logic [ADDR_BIT_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_BIT_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                      arvalid_q, arvalid_d, rready_q, rready_d;
  logic [DATA_BIT_WIDTH-1:0] rdata_q, rdata_d;
  axi4_resp_t                resp_q, resp_d;

  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

`ifdef AXI4_LITE_MST_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        pick_oh    = '0;
        pick_oh[k] = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
  end
  assign pick_any = |i_req_valid;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .req     (i_req_valid),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) ptr_q <= '0;
    else               ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    o_req_ready = '0;
    o_rsp_valid = '0;
`ifndef AXI4_LITE_MST_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          o_req_ready = pick_oh;
          gnt_d       = pick_idx;
          addr_d      = i_req_addr[pick_idx*ADDR_BIT_WIDTH +: ADDR_BIT_WIDTH];
          wdata_d     = i_req_wdata[pick_idx*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
          wstrb_d     = i_req_wstrb[pick_idx*STRB_W +: STRB_W];
          if (i_req_is_wr[pick_idx]) begin
            state_d   = ARB_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ARB_RD;
            arvalid_d = 1'b1;
          end
        end
      end
      // AW and W complete independently; leave only when both are done.
      ARB_WR: begin
        if (if_m_axi4_lite.awready) awvalid_d = 1'b0;
        if (if_m_axi4_lite.wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ARB_WR_RESP;
          bready_d = 1'b1;
        end
      end
      ARB_WR_RESP: begin
        if (if_m_axi4_lite.bvalid && bready_q) begin
          resp_d   = axi4_resp_t'(if_m_axi4_lite.bresp);
          rdata_d  = '0;
          bready_d = 1'b0;
          state_d  = ARB_RSP;
        end
      end
      ARB_RD: begin
        if (if_m_axi4_lite.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ARB_RD_DATA;
        end
      end
      ARB_RD_DATA: begin
        if (if_m_axi4_lite.rvalid && rready_q) begin
          resp_d   = axi4_resp_t'(if_m_axi4_lite.rresp);
          rdata_d  = if_m_axi4_lite.rdata;
          rready_d = 1'b0;
          state_d  = ARB_RSP;
        end
      end
      ARB_RSP: begin
        o_rsp_valid[gnt_q] = 1'b1;
`ifndef AXI4_LITE_MST_ARB_FIXED_PRIO_EN
        ptr_d = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
`endif
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    // Grant is combinational from IDLE, so it must also be masked by reset.
    if (!i_sync_rst_n) o_req_ready = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_sync_rst_n) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= AXI4_RESP_OKAY;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
    end
  end

  assign if_m_axi4_lite.awaddr  = addr_q;
  assign if_m_axi4_lite.awprot  = 3'b000;
  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.wdata   = wdata_q;
  assign if_m_axi4_lite.wstrb   = wstrb_q;
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.araddr  = addr_q;
  assign if_m_axi4_lite.arprot  = 3'b000;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.rready  = rready_q;

  assign o_rsp_rdata = rdata_q;
  assign o_rsp_resp  = resp_q;
  assign o_busy      = (state_q != ARB_IDLE);
endmodule
